mc_control_unit: RTL and testbench

- Multi-cycle control FSM that drives the 4-bit ALU operation code and consumes the ALU zero flag.
- Sequences one RV32I-subset instruction at a time through fetch, decode, execute, memory and writeback.
- Emits enables and mux selects for the PC, IR, register file and memory.
- Memory access uses a req/ready handshake, so the block stalls on slow memory.

---
 rtl/mc_control_unit_pkg.sv | 53 +++++
 rtl/mc_control_unit_if.sv | 22 ++
 rtl/mc_control_unit_alu_decode.sv | 59 +++++
 rtl/mc_control_unit.sv | 188 ++++++++++++++++++
 tb/tb_mc_control_unit.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mc_control_unit_pkg.sv
// Shared encodings for the multi-cycle control unit.
// ALU codes, opcodes, FSM states and datapath mux selects.
package ctrl_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_XOR   = 4'b0010;
  localparam logic [3:0] ALU_SRA   = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0101;
  localparam logic [3:0] ALU_ADD   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_PASSB = 4'b1100;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic       ADDR_PC  = 1'b0;
  localparam logic       ADDR_ALU = 1'b1;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_ALU   = 2'd1;
  localparam logic [1:0] PC_ALUAL = 2'd2;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;

  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_FOUR = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

endpackage

// File: rtl/mc_control_unit_if.sv
// Memory request/ready handshake between control unit and memory.
// Master drives request, write qualifier and address select.
interface mc_control_unit_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/mc_control_unit_alu_decode.sv
// ALU operation decode and decode-time legality check.
// ADD outside EXEC so DECODE precomputes PC + imm.
module mc_alu_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  state_t     i_state,
  output logic [3:0] o_alu_ctrl,
  output logic       o_illegal_dec
);

  logic w_alu_op;
  assign w_alu_op = (i_opcode == OP_R) || (i_opcode == OP_I);

  // legality of the current IR fields
  always_comb begin
    o_illegal_dec = 1'b0;
    case (i_opcode)
      OP_R, OP_I:
        o_illegal_dec = (i_funct3 == 3'b011) ||
                        (i_funct3 == 3'b101 && !i_funct7b5);
      OP_BR:
        o_illegal_dec = (i_funct3[2:1] == 2'b11);
      OP_LW, OP_SW:
        o_illegal_dec = (i_funct3 != 3'b010);
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC:
        o_illegal_dec = 1'b0;
      default:
        o_illegal_dec = 1'b1;
    endcase
  end

  // ALU operation for the current state
  always_comb begin
    o_alu_ctrl = ALU_ADD;
    if (i_state == S_EXEC) begin
      if (w_alu_op) begin
        case (i_funct3)
          3'b000: o_alu_ctrl = (i_opcode == OP_R && i_funct7b5) ?
                               ALU_SUB : ALU_ADD;
          3'b001: o_alu_ctrl = ALU_SLL;
          3'b010: o_alu_ctrl = ALU_SLT;
          3'b100: o_alu_ctrl = ALU_XOR;
          3'b101: o_alu_ctrl = ALU_SRA;
          3'b110: o_alu_ctrl = ALU_OR;
          3'b111: o_alu_ctrl = ALU_AND;
          default: o_alu_ctrl = ALU_ADD;
        endcase
      end else if (i_opcode == OP_BR) begin
        o_alu_ctrl = i_funct3[2] ? ALU_SLT : ALU_SUB;
      end else if (i_opcode == OP_LUI) begin
        o_alu_ctrl = ALU_PASSB;
      end
    end
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I-subset control FSM (fetch/decode/exec/mem/wb).
// Optional CTRL_PERF_CNT_EN adds cycle_cnt and instret_cnt outputs.
module mc_control_unit
  import ctrl_pkg::*;
#(
  parameter bit RESET_ERR_STICKY = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  mc_control_unit_if.master mem,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [1:0]  alu_a_sel,
  output logic [1:0]  alu_b_sel,
  output logic [3:0]  alu_ctrl,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic [2:0]  state_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  state_t r_state;
  state_t w_next;
  logic   r_illegal;
  logic   w_illegal_dec;
  logic   w_taken;
  logic   w_req, w_we, w_ir_we, w_pc_we, w_reg_we;

  mc_alu_decode u_dec (
    .i_opcode      (opcode),
    .i_funct3      (funct3),
    .i_funct7b5    (funct7b5),
    .i_state       (r_state),
    .o_alu_ctrl    (alu_ctrl),
    .o_illegal_dec (w_illegal_dec)
  );

  // BEQ/BNE compare via SUB, BLT/BGE via SLT result
  assign w_taken = funct3[0] ? (funct3[2] ? zero : !zero)
                             : (funct3[2] ? !zero : zero);

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // next state and Moore+IR control outputs
  always_comb begin
    w_next       = r_state;
    w_req        = 1'b0;
    w_we         = 1'b0;
    mem.addr_sel = ADDR_PC;
    w_ir_we      = 1'b0;
    w_pc_we      = 1'b0;
    w_reg_we     = 1'b0;
    pc_sel       = PC_PLUS4;
    alu_a_sel    = A_RS1;
    alu_b_sel    = B_RS2;
    wb_sel       = WB_ALU;
    case (r_state)
      S_FETCH: begin
        w_req = 1'b1;
        if (mem.mem_ready) begin
          w_ir_we = 1'b1;
          w_pc_we = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_a_sel = A_PC;
        alu_b_sel = B_IMM;
        w_next    = w_illegal_dec ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        case (opcode)
          OP_R: w_next = S_WB;
          OP_I: begin
            alu_b_sel = B_IMM;
            w_next    = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_b_sel = B_IMM;
            w_next    = S_MEM;
          end
          OP_BR: begin
            if (w_taken) begin
              w_pc_we = 1'b1;
              pc_sel  = PC_ALU;
            end
            w_next = S_FETCH;
          end
          OP_JAL: begin
            alu_a_sel = A_PC;
            alu_b_sel = B_IMM;
            w_pc_we   = 1'b1;
            pc_sel    = PC_ALU;
            w_next    = S_WB;
          end
          OP_JALR: begin
            alu_b_sel = B_IMM;
            w_pc_we   = 1'b1;
            pc_sel    = PC_ALUAL;
            w_next    = S_WB;
          end
          OP_LUI: begin
            alu_a_sel = A_ZERO;
            alu_b_sel = B_IMM;
            w_next    = S_WB;
          end
          OP_AUIPC: begin
            alu_a_sel = A_PC;
            alu_b_sel = B_IMM;
            w_next    = S_WB;
          end
          default: w_next = S_TRAP;
        endcase
      end
      S_MEM: begin
        w_req        = 1'b1;
        mem.addr_sel = ADDR_ALU;
        w_we         = (opcode == OP_SW);
        if (mem.mem_ready)
          w_next = (opcode == OP_SW) ? S_FETCH : S_WB;
      end
      S_WB: begin
        w_reg_we = 1'b1;
        if (opcode == OP_LW)
          wb_sel = WB_MEM;
        else if (opcode == OP_JAL || opcode == OP_JALR)
          wb_sel = WB_PC4;
        w_next = S_FETCH;
      end
      S_TRAP: w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  // nothing writes during the reset cycle
  assign mem.mem_req = w_req & ~rst;
  assign mem.mem_we  = w_we & ~rst;
  assign ir_we       = w_ir_we & ~rst;
  assign pc_we       = w_pc_we & ~rst;
  assign reg_we      = w_reg_we & ~rst;
  assign state_o     = r_state;
  assign illegal     = r_illegal;

  // illegal flag: set entering TRAP, optionally cleared in FETCH
  always_ff @(posedge clk) begin
    if (rst)
      r_illegal <= 1'b0;
    else if (w_next == S_TRAP)
      r_illegal <= 1'b1;
    else if (!RESET_ERR_STICKY && r_state == S_FETCH)
      r_illegal <= 1'b0;
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instret_cnt;

  // free-running cycle and retired-instruction counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt   <= 32'd0;
      r_instret_cnt <= 32'd0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (r_state != S_FETCH && w_next == S_FETCH)
        r_instret_cnt <= r_instret_cnt + 32'd1;
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit.
// Walks instruction classes and checks per-state control outputs.
module tb_mc_control_unit;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       ir_we, pc_we, reg_we, illegal;
  logic [1:0] pc_sel, alu_a_sel, alu_b_sel, wb_sel;
  logic [3:0] alu_ctrl;
  logic [2:0] state_o;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int n_tot = 0;
  int n_bad = 0;

  int         cyc, n_rw, n_mem;
  logic [3:0] e_alu;
  logic       e_pcwe, m_ok, m_we;
  logic [1:0] e_pcsel, w_wbsel;

  mc_control_unit_if mif();

  always #5 clk = ~clk;

  mc_control_unit #(.RESET_ERR_STICKY(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .zero      (zero),
    .mem       (mif),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .alu_ctrl  (alu_ctrl),
    .reg_we    (reg_we),
    .wb_sel    (wb_sel),
    .illegal   (illegal),
    .state_o   (state_o)
`ifdef CTRL_PERF_CNT_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [6:0] op, input logic [2:0] f3,
                     input logic f7, input logic z, input int stall);
    int st;
    st = stall;
    opcode = op; funct3 = f3; funct7b5 = f7; zero = z;
    cyc = 0; n_rw = 0; n_mem = 0;
    e_alu = 4'hf; e_pcwe = 1'b0; e_pcsel = 2'd3;
    w_wbsel = 2'd3; m_ok = 1'b1; m_we = 1'b0;
    do begin
      mif.mem_ready = 1'b1;
      if (state_o == 3'd3 && st > 0) begin
        mif.mem_ready = 1'b0;
        st--;
      end
      #1;
      if (state_o == 3'd2) begin
        e_alu = alu_ctrl; e_pcwe = pc_we; e_pcsel = pc_sel;
      end
      if (state_o == 3'd3) begin
        n_mem++;
        m_ok = m_ok & mif.mem_req & mif.addr_sel;
        m_we = m_we | mif.mem_we;
      end
      if (state_o == 3'd4) w_wbsel = wb_sel;
      if (reg_we) n_rw++;
      tick();
      cyc++;
    end while (state_o != 3'd0 && cyc < 30);
    mif.mem_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    opcode = OP_R; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    mif.mem_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_alu", 32'(alu_ctrl), 32'h6);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_en", {28'd0, mif.mem_req, ir_we, pc_we, reg_we}, 32'd0);
    chk("rst_sel", {24'd0, pc_sel, alu_a_sel, alu_b_sel, wb_sel}, 32'd0);
`ifdef CTRL_PERF_CNT_EN
    chk("rst_cycle", cycle_cnt, 32'd0);
`endif
    rst = 1'b0;
    #1;

    mif.mem_ready = 1'b0;
    tick();
    tick();
    chk("fstall_state", 32'(state_o), 32'd0);
    chk("fstall_req", 32'(mif.mem_req), 32'd1);
    chk("fstall_irwe", 32'(ir_we), 32'd0);
    mif.mem_ready = 1'b1;
    #1;
    chk("fetch_we", {30'd0, ir_we, pc_we}, 32'd3);

    run(OP_R, 3'b000, 1'b0, 1'b0, 0);
    chk("add_cyc", cyc, 32'd4);
    chk("add_alu", 32'(e_alu), 32'h6);
    chk("add_regwe", n_rw, 32'd1);
    chk("add_wbsel", 32'(w_wbsel), 32'd0);
    chk("add_end", 32'(state_o), 32'd0);

    run(OP_R, 3'b000, 1'b1, 1'b0, 0);
    chk("sub_alu", 32'(e_alu), 32'h5);
    run(OP_R, 3'b110, 1'b0, 1'b0, 0);
    chk("or_alu", 32'(e_alu), 32'h1);
    run(OP_R, 3'b111, 1'b0, 1'b0, 0);
    chk("and_alu", 32'(e_alu), 32'h0);
    run(OP_R, 3'b100, 1'b0, 1'b0, 0);
    chk("xor_alu", 32'(e_alu), 32'h2);
    run(OP_I, 3'b000, 1'b1, 1'b0, 0);
    chk("addi_alu", 32'(e_alu), 32'h6);

    run(OP_BR, 3'b000, 1'b0, 1'b1, 0);
    chk("beq_t_cyc", cyc, 32'd3);
    chk("beq_t_pc", {30'd0, e_pcwe, e_pcsel == 2'd1}, 32'd3);
    chk("beq_t_alu", 32'(e_alu), 32'h5);
    chk("beq_t_rw", n_rw, 32'd0);
    run(OP_BR, 3'b000, 1'b0, 1'b0, 0);
    chk("beq_n_cyc", cyc, 32'd3);
    chk("beq_n_pcwe", 32'(e_pcwe), 32'd0);
    run(OP_BR, 3'b101, 1'b0, 1'b1, 0);
    chk("bge_t_pcwe", 32'(e_pcwe), 32'd1);
    chk("bge_alu", 32'(e_alu), 32'h7);
    run(OP_BR, 3'b001, 1'b0, 1'b1, 0);
    chk("bne_n_pcwe", 32'(e_pcwe), 32'd0);

    run(OP_LW, 3'b010, 1'b0, 1'b0, 3);
    chk("lw_cyc", cyc, 32'd8);
    chk("lw_mem", n_mem, 32'd4);
    chk("lw_memok", 32'(m_ok), 32'd1);
    chk("lw_memwe", 32'(m_we), 32'd0);
    chk("lw_wbsel", 32'(w_wbsel), 32'd1);
    chk("lw_rw", n_rw, 32'd1);

    run(OP_JAL, 3'b000, 1'b0, 1'b0, 0);
    chk("jal_cyc", cyc, 32'd4);
    chk("jal_pc", {30'd0, e_pcsel}, 32'd1);
    chk("jal_wbsel", 32'(w_wbsel), 32'd2);
    run(OP_JALR, 3'b000, 1'b0, 1'b0, 0);
    chk("jalr_pc", {30'd0, e_pcsel}, 32'd2);
    run(OP_LUI, 3'b000, 1'b0, 1'b0, 0);
    chk("lui_alu", 32'(e_alu), 32'hc);
    chk("lui_cyc", cyc, 32'd4);

    opcode = 7'b1110011; funct3 = 3'b000;
    tick();
    tick();
    chk("ecall_state", 32'(state_o), 32'd7);
    chk("ecall_ill", 32'(illegal), 32'd1);
    tick();
    tick();
    tick();
    chk("trap_hold", {28'd0, state_o, illegal}, 32'hf);
    chk("trap_noreq", 32'(mif.mem_req), 32'd0);
    do_reset();
    #1;
    chk("trap_rst", {28'd0, state_o, illegal}, 32'd0);

    opcode = OP_R; funct3 = 3'b101; funct7b5 = 1'b0;
    tick();
    tick();
    chk("srl_trap", {28'd0, state_o, illegal}, 32'hf);
    do_reset();
    #1;
    chk("srl_rst", {28'd0, state_o, illegal}, 32'd0);

    opcode = OP_SW; funct3 = 3'b010; funct7b5 = 1'b0;
    tick();
    tick();
    tick();
    mif.mem_ready = 1'b0;
    #1;
    chk("sw_mem", {29'd0, state_o}, 32'd3);
    chk("sw_we", {30'd0, mif.mem_req, mif.mem_we}, 32'd3);
    rst = 1'b1;
    #1;
    chk("sw_rst_we", 32'(mif.mem_we), 32'd0);
    tick();
    chk("sw_rst_st", 32'(state_o), 32'd0);
    chk("sw_rst_we2", 32'(mif.mem_we), 32'd0);
    rst = 1'b0;
    mif.mem_ready = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
